// File: rtl/exc_pkg.sv
// Shared exception codes, CP0 register indices and types for the MEM-stage exception arbiter.
package exc_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_ADEL    = 32'h4;
    localparam logic [31:0] EXC_ADES    = 32'h5;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_BREAK   = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'ha;
    localparam logic [31:0] EXC_OVF     = 32'hc;
    localparam logic [31:0] EXC_TRAP    = 32'hd;
    localparam logic [31:0] EXC_ERET    = 32'he;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    typedef struct packed {
        logic fetch_adel;
        logic ri;
        logic ovf;
        logic trap;
        logic syscall;
        logic brk;
        logic data_adel;
        logic data_ades;
        logic eret;
    } exc_flags_t;

    typedef enum logic {
        StIdle,
        StShadow
    } exc_state_e;

    function automatic logic any_flag(input exc_flags_t f);
        return |f;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Per-bit flop chain that brings asynchronous interrupt lines into the clk domain.
module int_sync #(
    parameter int unsigned Width  = 6,
    parameter int unsigned Stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    // Fewer than two flops is not a synchroniser; clamp rather than build a broken one.
    localparam int unsigned Depth = (Stages < 2) ? 2 : Stages;

    logic [Width-1:0] sync_q [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: picks the winning exception, reports it to CP0 and
// flushes the pipeline, with a one-cycle shadow state to block a double commit.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    output logic [5:0]  int_sync_o,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [8:0]  mem_exc_flags_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_in_delayslot_o,
    output logic [31:0] exc_badaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    exc_state_e state_q, state_d;
    exc_flags_t flags;
    logic [31:0] status_eff;
    logic [31:0] epc_eff;
    logic [7:0]  cause_ip;
    logic        int_req;
    logic        commit;
    logic        unused_bits;

    int_sync #(
        .Width  (6),
        .Stages (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (int_i),
        .q_o (int_sync_o)
    );

    assign flags = exc_flags_t'(mem_exc_flags_i);

    assign status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i
                                                                       : cp0_status_i;
    assign epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC) ? wb_cp0_data_i : cp0_epc_i;

    // Only the software interrupt bits IP[1:0] are writable by mtc0, so only they forward.
    assign cause_ip = {cp0_cause_i[15:10],
                       (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE) ? wb_cp0_data_i[9:8]
                                                                   : cp0_cause_i[9:8]};

    assign int_req = status_eff[STATUS_IE] && !status_eff[STATUS_EXL] &&
                     |(cause_ip & status_eff[STATUS_IM_HI:STATUS_IM_LO]);

    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cp0_cause_i[31:16], cp0_cause_i[7:0]};

    assign commit = !rst && (state_q == StIdle) && !stall_i && mem_valid_i &&
                    (int_req || any_flag(flags));

    always_comb begin
        state_d            = state_q;
        excepttype_o       = EXC_NONE;
        exc_pc_o           = '0;
        exc_in_delayslot_o = 1'b0;
        exc_badaddr_o      = '0;
        flush_o            = 1'b0;
        new_pc_o           = '0;

        if (state_q == StShadow) begin
            state_d = StIdle;
        end

        if (commit) begin
            state_d            = StShadow;
            flush_o            = 1'b1;
            exc_pc_o           = mem_pc_i;
            exc_in_delayslot_o = mem_in_delayslot_i;
            new_pc_o           = EXC_VECTOR;
            if (int_req) begin
                excepttype_o = EXC_INT;
            end else if (flags.fetch_adel) begin
                excepttype_o  = EXC_ADEL;
                exc_badaddr_o = mem_pc_i;
            end else if (flags.ri) begin
                excepttype_o = EXC_RI;
            end else if (flags.ovf) begin
                excepttype_o = EXC_OVF;
            end else if (flags.trap) begin
                excepttype_o = EXC_TRAP;
            end else if (flags.syscall) begin
                excepttype_o = EXC_SYSCALL;
            end else if (flags.brk) begin
                excepttype_o = EXC_BREAK;
            end else if (flags.data_adel) begin
                excepttype_o  = EXC_ADEL;
                exc_badaddr_o = mem_addr_i;
            end else if (flags.data_ades) begin
                excepttype_o  = EXC_ADES;
                exc_badaddr_o = mem_addr_i;
            end else begin
                excepttype_o = EXC_ERET;
                new_pc_o     = epc_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
